dram_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters: the CPU load/store path and a debug port (UART memory peek/poke, dump engine).
- Sits between the CPU's RAM address/data nets and the `ram` instance.
- Grants one access per cycle.
- Bounds debug starvation with a counter, supports locked debug bursts and routes read data back to the issuing requester.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/dram_arbiter_rd_tag_pipe.sv | 36 +++
 rtl/dram_arbiter.sv | 105 ++++++++++
 tb/tb_dram_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared owner/state enums and RAM width constants
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    typedef enum logic {
        ARB      = 1'b0,
        DBG_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dram_arbiter_rd_tag_pipe.sv
// rtl/dram_arbiter_rd_tag_pipe.sv - read-tag delay line steering RAM read data to its issuer
module rd_tag_pipe
    import cpu_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_valid,
    input  owner_e push_owner,
    output logic   cpu_rvalid,
    output logic   dbg_rvalid
);

    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_own;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_own   <= '0;
        end else begin
            tag_valid[0] <= push_valid;
            tag_own[0]   <= push_owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_own[i]   <= tag_own[i-1];
            end
        end
    end

    // The tag leaving the last stage lines up with the RAM data for that read
    assign cpu_rvalid = tag_valid[RD_LAT-1] && (tag_own[RD_LAT-1] == OWN_CPU);
    assign dbg_rvalid = tag_valid[RD_LAT-1] && (tag_own[RD_LAT-1] == OWN_DBG);

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - CPU/debug arbiter for the single-port data RAM
module dram_arbiter #(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int STARVE_MAX = 3,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_paused,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import cpu_pkg::*;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       dbg_win, cpu_win;
    logic       push_valid;
    owner_e     push_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        dbg_win    = 1'b0;
        cpu_win    = 1'b0;
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            ARB: begin
                dbg_win = dbg_req && (!cpu_req || cpu_paused || starve_cnt == STARVE_LIM);
                cpu_win = cpu_req && !dbg_win;
                if (dbg_win && dbg_lock) begin
                    state_nxt = DBG_LOCK;
                end
                // Only a contested CPU win ages the debug requester
                if (cpu_win && dbg_req) begin
                    starve_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
                end else begin
                    starve_nxt = '0;
                end
            end
            DBG_LOCK: begin
                dbg_win = dbg_req;
                if (!dbg_lock) begin
                    state_nxt  = ARB;
                    starve_nxt = '0;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    assign ram_addr  = dbg_win ? dbg_addr  : cpu_addr;
    assign ram_wdata = dbg_win ? dbg_wdata : cpu_wdata;
    assign ram_we    = !rst && (dbg_win ? dbg_we : (cpu_win && cpu_we));
    assign dbg_gnt   = !rst && dbg_win;
    assign cpu_stall = !rst && cpu_req && !cpu_win;

    assign push_valid = !rst && ((dbg_win && !dbg_we) || (cpu_win && !cpu_we));
    assign push_owner = dbg_win ? OWN_DBG : OWN_CPU;

    rd_tag_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .push_valid(push_valid),
        .push_owner(push_owner),
        .cpu_rvalid(cpu_rvalid),
        .dbg_rvalid(dbg_rvalid)
    );

    assign cpu_rdata = ram_rdata;
    assign dbg_rdata = ram_rdata;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed scoreboard bench for dram_arbiter
module tb_dram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SM = 3;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_paused = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic          dbg_lock = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic          own;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sbq[$];

    logic [DW-1:0] shadow [256];
    logic [DW-1:0] mem [256];
    logic [255:0]  wr_mask = '0;
    logic [DW-1:0] rd_pipe [RL];

    dram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .RD_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst), .cpu_paused(cpu_paused),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a ^ 8'hA5;
    endfunction

    // RAM model: unwritten locations hold pat(addr), reads take RL cycles
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            wr_mask[ram_addr] <= 1'b1;
        end
        rd_pipe[0] <= wr_mask[ram_addr] ? mem[ram_addr] : pat(ram_addr);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RL-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1 || dbg_rvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rvalid_owner", 32'({cpu_rvalid, dbg_rvalid}), e.own ? 32'd1 : 32'd2);
                chk("rdata", 32'(e.own ? dbg_rdata : cpu_rdata), 32'(e.data));
                chk("rvalid_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            chk("rvalid_missing", 32'(cyc), 32'(sbq[0].due));
            void'(sbq.pop_front());
        end
    end

    // win: 0 none, 1 CPU, 2 debug. Starts and ends 1 time unit after a rising edge.
    task automatic step(input string tag, input logic p,
                        input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic dr, input logic dw, input logic dl,
                        input logic [7:0] da, input logic [7:0] dd, input int win);
        logic          e_we;
        logic [AW-1:0] e_addr;
        cpu_paused = p;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
        #2;
        e_we   = (win == 1) ? cw : (win == 2) ? dw : 1'b0;
        e_addr = (win == 2) ? da : ca;
        chk({tag, "_gnt"},   32'(dbg_gnt),   32'(win == 2));
        chk({tag, "_stall"}, 32'(cpu_stall), 32'(cr && win != 1));
        chk({tag, "_we"},    32'(ram_we),    32'(e_we));
        chk({tag, "_addr"},  32'(ram_addr),  32'(e_addr));
        if (win == 1 && !cw) sbq.push_back('{1'b0, shadow[ca], cyc + RL});
        if (win == 1 && cw)  shadow[ca] = cd;
        if (win == 2 && !dw) sbq.push_back('{1'b1, shadow[da], cyc + RL});
        if (win == 2 && dw)  shadow[da] = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i));

        // Reset asserted mid-cycle with both requesters active
        cpu_req = 1'b1; dbg_req = 1'b1;
        #7 rst = 1'b1;
        #1;
        chk("rst_we",     32'(ram_we),     32'd0);
        chk("rst_gnt",    32'(dbg_gnt),    32'd0);
        chk("rst_stall",  32'(cpu_stall),  32'd0);
        chk("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        chk("rst_hold_gnt",   32'(dbg_gnt),   32'd0);
        chk("rst_hold_stall", 32'(cpu_stall), 32'd0);
        cpu_req = 1'b0; dbg_req = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        idle(RL + 1);

        // CPU-only write then read of the same address
        step("cpu_wr", 0, 1, 1, 8'h10, 8'h5A, 0, 0, 0, 8'h00, 8'h00, 1);
        step("cpu_rd", 0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
        idle(RL + 1);

        // Starvation bound: debug forced through every fourth contested cycle
        for (int i = 0; i < 8; i++)
            step("starve", 0, 1, 0, 8'(32'h20 + i), 8'h00, 1, 0, 0, 8'(32'h30 + i), 8'h00,
                 (i % 4 == 3) ? 2 : 1);
        idle(1);

        // Locked burst: enter on the forced grant, hold for eight reads
        for (int i = 0; i < 3; i++)
            step("lock_pre", 0, 1, 0, 8'h50, 8'h00, 1, 0, 1, 8'h00, 8'h00, 1);
        for (int a = 0; a < 8; a++)
            step("burst", 0, 1, 0, 8'h50, 8'h00, 1, 0, (a != 7), 8'(a), 8'h00, 2);
        step("post_lock", 0, 1, 0, 8'h51, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
        step("post_cont", 0, 1, 0, 8'h52, 8'h00, 1, 0, 0, 8'h08, 8'h00, 1);
        idle(RL + 1);

        // cpu_paused gives debug unconditional priority
        step("pause_wr0", 1, 1, 0, 8'h60, 8'h00, 1, 1, 0, 8'h40, 8'h11, 2);
        step("pause_wr1", 1, 1, 0, 8'h60, 8'h00, 1, 1, 0, 8'h41, 8'h22, 2);
        step("pause_rd",  1, 1, 0, 8'h60, 8'h00, 1, 0, 0, 8'h40, 8'h00, 2);
        step("pause_cpu", 1, 1, 0, 8'h41, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
        step("unpause",   0, 1, 0, 8'h40, 8'h00, 1, 0, 0, 8'h41, 8'h00, 1);
        step("lock_noreq", 0, 1, 0, 8'h61, 8'h00, 0, 0, 1, 8'h00, 8'h00, 1);
        step("after_noreq", 0, 1, 0, 8'h62, 8'h00, 1, 0, 0, 8'h63, 8'h00, 1);
        idle(RL + 1);

        // Reset with a read in flight: tag is dropped
        step("inflight", 0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1);
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("rst2_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst", 0, 1, 0, 8'h70, 8'h00, 1, 0, 0, 8'h71, 8'h00, 1);
        idle(RL + 2);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
